// File: rtl/life_pkg.sv
// life_pkg: shared geometry and FSM encoding for the life generation sequencer.
package life_pkg;
    localparam int ROWS = 20;
    localparam int COLS = 20;
    localparam int AW   = 5;
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_CALC  = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] v);
        return (v == AW'(ROWS - 1)) ? '0 : v + 1'b1;
    endfunction
endpackage

// File: rtl/row_wrap_ctr.sv
// row_wrap_ctr: modulo-ROWS row counter with synchronous load and increment.
module row_wrap_ctr
    import life_pkg::*;
#(
    parameter logic [AW-1:0] RST_VAL = '0
) (
    input  logic          clk_50MHz_i,
    input  logic          rst_i,
    input  logic          load,
    input  logic [AW-1:0] load_val,
    input  logic          inc,
    output logic [AW-1:0] q
);
    always_ff @(posedge clk_50MHz_i) begin
        if (rst_i)
            q <= RST_VAL;
        else if (load)
            q <= load_val;
        else if (inc)
            q <= wrap_inc(q);
    end
endmodule

// File: rtl/life_gen_sequencer.sv
// life_gen_sequencer: walks the 20 rows of a life board, preloading a 3-row window,
// requesting the cell computation for each centre row and writing the result back.
module life_gen_sequencer
    import life_pkg::*;
(
    input  logic          clk_50MHz_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic          calc_ack_i,
    output logic          rd_en_o,
    output logic [AW-1:0] rd_addr_o,
    output logic          sipo_en_o,
    output logic          calc_req_o,
    output logic          wr_en_o,
    output logic [AW-1:0] wr_addr_o,
    output logic          busy_o,
    output logic          done_o
);
    logic [2:0]    state, nxt;
    logic [1:0]    p;
    logic [AW-1:0] r, f;
    logic          go, preload, last_row, adv;

    assign go       = (state == S_IDLE) && start_i;
    assign preload  = (state == S_SHIFT) && (p < 2'd2);
    assign last_row = (r == AW'(ROWS - 1));
    assign adv      = (state == S_WRITE) && !last_row;

    always_comb begin
        nxt = S_IDLE;
        case (state)
            S_IDLE:  nxt = start_i ? S_READ : S_IDLE;
            S_READ:  nxt = S_SHIFT;
            S_SHIFT: nxt = preload ? S_READ : S_CALC;
            S_CALC:  nxt = calc_ack_i ? S_WRITE : S_CALC;
            S_WRITE: nxt = last_row ? S_DONE : S_READ;
            default: nxt = S_IDLE;
        endcase
    end

    row_wrap_ctr #(.RST_VAL('0)) u_row (
        .clk_50MHz_i (clk_50MHz_i),
        .rst_i       (rst_i),
        .load        (go),
        .load_val    ('0),
        .inc         (adv),
        .q           (r)
    );

    // the fetch pointer runs one row ahead of the centre row once preload is done
    row_wrap_ctr #(.RST_VAL(AW'(ROWS - 1))) u_fetch (
        .clk_50MHz_i (clk_50MHz_i),
        .rst_i       (rst_i),
        .load        (go),
        .load_val    (AW'(ROWS - 1)),
        .inc         (preload || adv),
        .q           (f)
    );

    always_ff @(posedge clk_50MHz_i) begin
        if (rst_i) begin
            state      <= S_IDLE;
            p          <= '0;
            rd_en_o    <= 1'b0;
            sipo_en_o  <= 1'b0;
            calc_req_o <= 1'b0;
            wr_en_o    <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            state      <= nxt;
            p          <= go ? 2'd0 : preload ? p + 2'd1 : p;
            rd_en_o    <= (nxt == S_READ);
            sipo_en_o  <= (nxt == S_SHIFT);
            calc_req_o <= (nxt == S_CALC);
            wr_en_o    <= (nxt == S_WRITE);
            busy_o     <= (nxt != S_IDLE);
            done_o     <= (nxt == S_DONE);
        end
    end

    assign rd_addr_o = rd_en_o ? f : '0;
    assign wr_addr_o = wr_en_o ? r : '0;
endmodule
